// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Width of the stale-response counter; it saturates at all-ones.
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a synchronous flush and an asynchronous active-low reset.
// Holds both the in-flight PC list and the fetch queue.
module fetch_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap explicitly so that non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/if_fetch_queue_chk.sv
// Protocol and overflow checks for the fetch stage; carries no design logic.
module if_fetch_queue_chk #(
  parameter int DW = 8
) (
  input logic          clk,
  input logic          rst,
  input logic          rsp_valid,
  input logic          infl_empty,
  input logic          infl_full,
  input logic          infl_push,
  input logic          q_full,
  input logic          q_push,
  input logic [DW-1:0] drop_cnt
);

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    rsp_valid |-> (!infl_empty || (drop_cnt != {DW{1'b0}})));

  a_infl_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    infl_push |-> !infl_full);

  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    q_push |-> !q_full);

  a_drop_no_saturate: assert property (@(posedge clk) disable iff (!rst)
    drop_cnt != {DW{1'b1}});

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues PC-sequential requests, buffers in-order responses
// in a fetch queue for decode, and restarts at a redirect target discarding stale data.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int              XLEN            = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC),
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2,
  localparam int             CW              = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_npc,
  output logic [XLEN-1:0] if_ir,
  output logic [CW-1:0]   if_count
);

  localparam int              OW         = $clog2(MAX_OUTSTANDING + 1);
  localparam int              DW1        = DROP_W + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  logic [XLEN-1:0]   fetch_pc_r;
  logic [XLEN-1:0]   fetch_pc_nxt_s;
  logic [DROP_W-1:0] drop_cnt_r;
  logic [DROP_W-1:0] drop_nxt_s;
  logic [DW1-1:0]    drop_total_s;
  logic [DW1-1:0]    drop_left_s;
  logic [OW-1:0]     outstanding_s;
  logic [XLEN-1:0]   infl_head_s;
  logic              infl_empty_s;
  logic              infl_full_s;
  logic [2*XLEN-1:0] q_head_s;
  logic              q_empty_s;
  logic              q_full_s;
  logic [CW-1:0]     q_count_s;
  logic              req_valid_s;
  logic              req_fire_s;
  logic              rsp_live_s;
  logic              rsp_drop_s;
  logic              q_push_s;
  logic              q_pop_s;

  // Credit rule: every issued request is guaranteed a queue slot, so responses never stall.
  assign req_valid_s = rst && !redirect_valid
                    && (int'(outstanding_s) < MAX_OUTSTANDING)
                    && ((int'(outstanding_s) + int'(q_count_s)) < QUEUE_DEPTH);
  assign req_fire_s  = req_valid_s && imem_req_ready;
  assign rsp_drop_s  = imem_rsp_valid && (drop_cnt_r != {DROP_W{1'b0}});
  assign rsp_live_s  = imem_rsp_valid && (drop_cnt_r == {DROP_W{1'b0}}) && !infl_empty_s;
  assign q_push_s    = rsp_live_s && !redirect_valid;
  assign q_pop_s     = if_valid && if_ready;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire_s),
    .pop   (rsp_live_s),
    .flush (redirect_valid),
    .wdata (fetch_pc_r),
    .rdata (infl_head_s),
    .full  (infl_full_s),
    .empty (infl_empty_s),
    .count (outstanding_s)
  );

  fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push_s),
    .pop   (q_pop_s),
    .flush (redirect_valid),
    .wdata ({infl_head_s, imem_rsp_data}),
    .rdata (q_head_s),
    .full  (q_full_s),
    .empty (q_empty_s),
    .count (q_count_s)
  );

  // On redirect the in-flight list is flushed, so its requests move into drop_cnt.
  assign drop_total_s = DW1'(outstanding_s) + DW1'(drop_cnt_r);
  assign drop_left_s  = (imem_rsp_valid && (drop_total_s != {DW1{1'b0}}))
                      ? drop_total_s - DW1'(1) : drop_total_s;

  // Next fetch PC and stale-response count
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    drop_nxt_s     = drop_cnt_r;
    if (redirect_valid) begin
      fetch_pc_nxt_s = redirect_pc & ALIGN_MASK;
      drop_nxt_s     = drop_left_s[DROP_W] ? {DROP_W{1'b1}} : drop_left_s[DROP_W-1:0];
    end else begin
      if (req_fire_s) fetch_pc_nxt_s = fetch_pc_r + XLEN'(4);
      else            fetch_pc_nxt_s = fetch_pc_r;
      if (rsp_drop_s) drop_nxt_s = drop_cnt_r - DROP_W'(1);
      else            drop_nxt_s = drop_cnt_r;
    end
  end

  // Fetch PC and drop counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC & ALIGN_MASK;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      drop_cnt_r <= drop_nxt_s;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r & ALIGN_MASK;
  assign if_valid       = !q_empty_s;
  assign if_pc          = if_valid ? q_head_s[2*XLEN-1:XLEN] : {XLEN{1'b0}};
  assign if_npc         = if_valid ? q_head_s[2*XLEN-1:XLEN] + XLEN'(4) : {XLEN{1'b0}};
  assign if_ir          = if_valid ? q_head_s[XLEN-1:0] : {XLEN{1'b0}};
  assign if_count       = q_count_s;

  if_fetch_queue_chk #(.DW(DROP_W)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .rsp_valid  (imem_rsp_valid),
    .infl_empty (infl_empty_s),
    .infl_full  (infl_full_s),
    .infl_push  (req_fire_s),
    .q_full     (q_full_s),
    .q_push     (q_push_s),
    .drop_cnt   (drop_cnt_r)
  );

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage that replaces the single-register fetch.
- Issues PC-sequential requests to instruction memory over a valid/ready request channel and accepts in-order responses of variable latency.
- Buffers fetched instructions with their PCs in a fetch queue and presents them to decode through a valid/ready handshake.
- A branch redirect flushes the queue, discards stale in-flight responses, and restarts fetch at the target.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 0, fetch PC after reset.
- QUEUE_DEPTH, 4, fetch-queue entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum in-flight memory requests (1..QUEUE_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- redirect_valid  in  1  taken branch/exception; takes priority over all other events.
- redirect_pc  in  XLEN  new fetch target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  XLEN  instruction word.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts head (stall when 0).
- if_pc  out  XLEN  head PC.
- if_npc  out  XLEN  head PC+4.
- if_ir  out  XLEN  head instruction.
- if_count  out  $clog2(QUEUE_DEPTH+1)  queue occupancy.

Behaviour:
- State:
  - fetch_pc.
  - In-flight PC FIFO (depth MAX_OUTSTANDING), count = outstanding.
  - Fetch queue (depth QUEUE_DEPTH) holding {pc, ir}.
  - drop_cnt.
- Reset (async, rst=0):
  - fetch_pc = RESET_PC, both FIFOs empty, drop_cnt = 0.
  - imem_req_valid = 0, if_valid = 0, if_count = 0, if_pc/if_npc/if_ir = 0.
- Address:
  - imem_req_addr = {fetch_pc[XLEN-1:2], 2'b00}.
- Request issue:
  - imem_req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING && (outstanding + if_count) < QUEUE_DEPTH.
  - This credit rule guarantees every response has a queue slot. Responses are never back-pressured and must be accepted.
  - On valid && ready: push fetch_pc into the in-flight FIFO and set fetch_pc += 4 (wraps modulo 2^XLEN).
- Response:
  - On imem_rsp_valid, pop the in-flight FIFO.
  - If drop_cnt == 0, push {pc, imem_rsp_data} into the fetch queue. Otherwise discard and decrement drop_cnt.
  - A response while outstanding == 0 is a protocol error; assert in simulation and ignore.
- Dequeue:
  - if_valid = queue non-empty, driven from registered storage.
  - Head is popped when if_valid && if_ready.
  - if_npc = if_pc + 4.
- Redirect, cycle t:
  - fetch_pc <= redirect_pc (low 2 bits forced 0).
  - Fetch queue cleared; if_valid = 0 at t+1.
  - drop_cnt <= outstanding + drop_cnt − (imem_rsp_valid ? 1 : 0), counting only responses not yet returned.
  - A response arriving in cycle t is dropped.
  - No request is issued in cycle t. The first request at the target is presented at t+1.
  - Dequeue in cycle t is allowed; the consumer sees it as the last pre-redirect instruction.
- Latency:
  - Request accepted at t, response at t+L: entry visible on if_valid at t+L+1.
  - Sustained throughput is 1 instruction/cycle when MAX_OUTSTANDING ≥ L+1 and if_ready = 1.
- Full queue:
  - With if_count == QUEUE_DEPTH, imem_req_valid = 0.
  - A same-cycle dequeue does not enable issue until the next cycle (credit uses registered count).
- Simultaneous push and pop on the queue: count unchanged, both take effect.
- Redirect while imem_req_valid=1 and ready=0: request withdrawn. The memory must tolerate valid deasserting without acceptance, but only on redirect.
- Reset mid-operation: everything clears immediately. Instruction memory must be reset in the same domain; post-reset responses to pre-reset requests are not supported.

Decomposition:
- Shared package (if_pkg): XLEN default, fetch_entry_t {pc, ir}, RESET_PC constant.
- Sub-module: fetch_fifo, a parametrised synchronous FIFO (WIDTH, DEPTH) with push, pop, flush, full, empty, count, and async active-low reset.
- fetch_fifo is instantiated twice: the in-flight PC FIFO and the fetch queue.

Test Plan:
- Reset release, memory latency 1, if_ready=1: requests at 0x0, 0x4, 0x8, …; if_valid first high 2 cycles after the first accept with if_pc=0x0, if_npc=0x4; then one instruction/cycle.
- if_ready=0, latency 1, DEPTH=4: if_count reaches 4 and imem_req_valid drops to 0. Set if_ready=1: entries 0x0, 0x4, 0x8, 0xC drain in order and fetch resumes at 0x10.
- Latency 3, MAX_OUTSTANDING=2, two requests in flight: redirect_valid with redirect_pc=0x103. Both responses are discarded, the next request address is 0x100, and the first if_pc after redirect is 0x100.
- Redirect in the same cycle as imem_rsp_valid and a queue pop: response dropped, queue empty next cycle, drop_cnt equals remaining in-flight count.
- imem_req_ready held 0 for 5 cycles: fetch_pc and imem_req_addr stay stable, no queue change; accept on cycle 6 increments fetch_pc by 4.
- Assert rst=0 asynchronously mid-stream, between clock edges: all outputs go to reset values immediately; after release, fetch restarts at RESET_PC.
